ssd_scan_reader: RTL and testbench

- Receive-side counterpart to the segment decoders. Observes a time-multiplexed, active-low 7-segment bus: segment lines plus one-hot active-low digit selects.
- Recovers the 4-bit hex value shown on each digit, with blank and error flags.
- Used for display loopback checking and for capturing the display state of external boards.
- A digit is accepted only after its pattern has been stable for a programmable number of cycles.

---
 rtl/ssd_pkg.sv | 62 ++++++
 rtl/ssd_scan_reader_if.sv | 25 ++
 rtl/ssd_pattern_decode.sv | 11 +
 rtl/ssd_scan_reader.sv | 193 +++++++++++++++++++
 tb/tb_ssd_scan_reader.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/ssd_pkg.sv
// Shared definitions for the 7-segment scan reader: active-low segment patterns,
// FSM state type and the pattern-to-value decode function.
package ssd_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      IDLE,
      TRACK,
      LOCKED
   } state_e;

   typedef struct packed {
      logic       err;
      logic       blank;
      logic [3:0] code;
   } decode_t;

   // Unrecognised patterns report err with a zero code; the caller keeps its old code.
   function automatic decode_t decodeSeg(input logic [6:0] seg);
      decode_t res;
      res = '0;
      case (seg)
         SEG_0:     res.code = 4'h0;
         SEG_1:     res.code = 4'h1;
         SEG_2:     res.code = 4'h2;
         SEG_3:     res.code = 4'h3;
         SEG_4:     res.code = 4'h4;
         SEG_5:     res.code = 4'h5;
         SEG_6:     res.code = 4'h6;
         SEG_7:     res.code = 4'h7;
         SEG_8:     res.code = 4'h8;
         SEG_9:     res.code = 4'h9;
         SEG_A:     res.code = 4'hA;
         SEG_B:     res.code = 4'hB;
         SEG_C:     res.code = 4'hC;
         SEG_D:     res.code = 4'hD;
         SEG_E:     res.code = 4'hE;
         SEG_F:     res.code = 4'hF;
         SEG_BLANK: res.blank = 1'b1;
         default:   res.err = 1'b1;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/ssd_scan_reader_if.sv
// Bus between a multiplexed 7-segment display source and the scan reader,
// carrying the raw display lines, the clear request and the recovered digits.
interface ssd_scan_reader_if #(
   parameter int NUM_DIGITS = 4
);
   logic [6:0]              seg_n;
   logic [NUM_DIGITS-1:0]   dig_sel_n;
   logic                    clear;
   logic [4*NUM_DIGITS-1:0] digit_code;
   logic [NUM_DIGITS-1:0]   digit_valid;
   logic [NUM_DIGITS-1:0]   digit_blank;
   logic [NUM_DIGITS-1:0]   digit_err;
   logic                    upd_stb;
   logic [2:0]              upd_idx;

   modport master (
      output seg_n, dig_sel_n, clear,
      input  digit_code, digit_valid, digit_blank, digit_err, upd_stb, upd_idx
   );

   modport slave (
      input  seg_n, dig_sel_n, clear,
      output digit_code, digit_valid, digit_blank, digit_err, upd_stb, upd_idx
   );
endinterface

// File: rtl/ssd_pattern_decode.sv
// Combinational table lookup from an active-low segment pattern to {err, blank, code}.
module ssd_pattern_decode
   import ssd_pkg::*;
(
   input  logic [6:0] seg_i,
   output decode_t    dec_o
);

   assign dec_o = decodeSeg(seg_i);

endmodule

// File: rtl/ssd_scan_reader.sv
// Samples a multiplexed active-low 7-segment bus and, once a digit's pattern has been
// stable long enough, records its decoded value in per-digit registers.
module ssd_scan_reader
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   ssd_scan_reader_if.slave  bus
);

   logic [6:0]              segMeta_q, segSync_q;
   logic [NUM_DIGITS-1:0]   selMeta_q, selSync_q;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [6:0]              refSeg_q, refSeg_d;
   logic [NUM_DIGITS-1:0]   refSel_q, refSel_d;

   logic [4*NUM_DIGITS-1:0] code_q, code_d;
   logic [NUM_DIGITS-1:0]   valid_q, valid_d;
   logic [NUM_DIGITS-1:0]   blank_q, blank_d;
   logic [NUM_DIGITS-1:0]   err_q, err_d;
   logic                    stb_q, stb_d;
   logic [2:0]              idx_q, idx_d;

   logic [3:0]              zeroCount;
   logic                    selLegal;
   logic                    sampleMatch;
   logic                    accept;
   logic [2:0]              refIdx;
   decode_t                 refDec;

   // Two-flop synchronisers for the display lines, which are asynchronous to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         segMeta_q <= '0;
         segSync_q <= '0;
         selMeta_q <= '0;
         selSync_q <= '0;
      end else begin
         segMeta_q <= bus.seg_n;
         segSync_q <= segMeta_q;
         selMeta_q <= bus.dig_sel_n;
         selSync_q <= selMeta_q;
      end
   end

   always_comb begin
      zeroCount = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!selSync_q[i]) begin
            zeroCount = zeroCount + 4'd1;
         end
      end
   end

   always_comb begin
      refIdx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!refSel_q[i]) begin
            refIdx = 3'(i);
         end
      end
   end

   assign selLegal    = (zeroCount == 4'd1);
   assign sampleMatch = (selSync_q == refSel_q) && (segSync_q == refSeg_q);

   ssd_pattern_decode uDecode (
      .seg_i (refSeg_q),
      .dec_o (refDec)
   );

   // State and counter registers of the stability tracker.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         refSeg_q <= '0;
         refSel_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         refSeg_q <= refSeg_d;
         refSel_q <= refSel_d;
      end
   end

   // Accept fires on the sample that brings the run length up to STABLE_CYCLES;
   // in LOCKED the counter is frozen so a long-held digit is never re-accepted.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      refSeg_d = refSeg_q;
      refSel_d = refSel_q;
      accept   = 1'b0;
      case (state_q)
         IDLE: begin
            count_d = '0;
            if (selLegal) begin
               state_d  = TRACK;
               count_d  = CNT_W'(1);
               refSeg_d = segSync_q;
               refSel_d = selSync_q;
            end
         end
         TRACK: begin
            if (!selLegal) begin
               state_d = IDLE;
               count_d = '0;
            end else if (!sampleMatch) begin
               count_d  = CNT_W'(1);
               refSeg_d = segSync_q;
               refSel_d = selSync_q;
            end else if (count_q == CNT_W'(STABLE_CYCLES - 1)) begin
               state_d = LOCKED;
               count_d = CNT_W'(STABLE_CYCLES);
               accept  = 1'b1;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         LOCKED: begin
            if (!selLegal) begin
               state_d = IDLE;
               count_d = '0;
            end else if (!sampleMatch) begin
               state_d  = TRACK;
               count_d  = CNT_W'(1);
               refSeg_d = segSync_q;
               refSel_d = selSync_q;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   // Clear drops every flag first; an accept in the same cycle then re-sets its own digit.
   always_comb begin
      code_d  = code_q;
      valid_d = bus.clear ? '0 : valid_q;
      blank_d = bus.clear ? '0 : blank_q;
      err_d   = bus.clear ? '0 : err_q;
      stb_d   = accept;
      idx_d   = idx_q;
      if (accept) begin
         idx_d = refIdx;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (refIdx == 3'(i)) begin
               valid_d[i] = 1'b1;
               blank_d[i] = refDec.blank;
               err_d[i]   = refDec.err;
               if (!refDec.err) begin
                  code_d[4*i +: 4] = refDec.code;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q  <= '0;
         valid_q <= '0;
         blank_q <= '0;
         err_q   <= '0;
         stb_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         code_q  <= code_d;
         valid_q <= valid_d;
         blank_q <= blank_d;
         err_q   <= err_d;
         stb_q   <= stb_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.digit_code  = code_q;
   assign bus.digit_valid = valid_q;
   assign bus.digit_blank = blank_q;
   assign bus.digit_err   = err_q;
   assign bus.upd_stb     = stb_q;
   assign bus.upd_idx     = idx_q;

endmodule

// File: tb/tb_ssd_scan_reader.sv
// Self-checking bench for ssd_scan_reader: directed scenarios followed by random scans,
// compared every cycle against a run-length reference model of the display stream.
module tb_ssd_scan_reader;

   localparam int ND = 4;
   localparam int SC = 4;

   logic clk = 1'b0;
   logic rst_n;

   ssd_scan_reader_if #(.NUM_DIGITS(ND)) bus ();

   ssd_scan_reader #(
      .NUM_DIGITS    (ND),
      .STABLE_CYCLES (SC),
      .CNT_W         (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int stbCount = 0;
   int firstStb = -1;
   int edgeCount = 0;

   logic [6:0] patTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic [6:0]      hSeg1, hSeg2, prevSeg;
   logic [ND-1:0]   hSel1, hSel2, prevSel;
   int              run;
   logic [4*ND-1:0] mCode;
   logic [ND-1:0]   mValid, mBlank, mErr;
   logic            mStb;
   logic [2:0]      mIdx;

   // Returns 0..15 for a hex glyph, 16 for blank, -1 for anything unrecognised.
   function automatic int decodeModel(input logic [6:0] s);
      if (s == 7'h7F) return 16;
      for (int k = 0; k < 16; k++) begin
         if (patTable[k] == s) return k;
      end
      return -1;
   endfunction

   task automatic modelReset();
      hSeg1 = '0; hSeg2 = '0; hSel1 = '0; hSel2 = '0;
      prevSeg = '0; prevSel = '0; run = 0;
      mCode = '0; mValid = '0; mBlank = '0; mErr = '0; mStb = 1'b0; mIdx = '0;
   endtask

   // A digit is accepted when the run of identical legal samples (seen two edges late)
   // first reaches SC.
   task automatic modelEdge(input logic [6:0] seg, input logic [ND-1:0] sel, input logic clr);
      logic [6:0]    sSeg;
      logic [ND-1:0] sSel;
      int zeros, pos, val;
      sSeg = hSeg2;
      sSel = hSel2;
      zeros = 0;
      pos = 0;
      for (int i = 0; i < ND; i++) begin
         if (!sSel[i]) begin
            zeros++;
            pos = i;
         end
      end
      if (zeros != 1) run = 0;
      else if (run > 0 && sSeg == prevSeg && sSel == prevSel) run++;
      else run = 1;
      prevSeg = sSeg;
      prevSel = sSel;
      if (clr) begin
         mValid = '0; mBlank = '0; mErr = '0;
      end
      mStb = (run == SC);
      if (mStb) begin
         mIdx = 3'(pos);
         mValid[pos] = 1'b1;
         val = decodeModel(sSeg);
         if (val == 16) begin
            mBlank[pos] = 1'b1; mErr[pos] = 1'b0; mCode[4*pos +: 4] = 4'h0;
         end else if (val < 0) begin
            mBlank[pos] = 1'b0; mErr[pos] = 1'b1;
         end else begin
            mBlank[pos] = 1'b0; mErr[pos] = 1'b0; mCode[4*pos +: 4] = 4'(val);
         end
      end
      hSeg2 = hSeg1; hSel2 = hSel1;
      hSeg1 = seg;   hSel1 = sel;
   endtask

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkEq({tag, ":stb"},   32'(bus.upd_stb),     32'(mStb));
      checkEq({tag, ":idx"},   32'(bus.upd_idx),     32'(mIdx));
      checkEq({tag, ":code"},  32'(bus.digit_code),  32'(mCode));
      checkEq({tag, ":valid"}, 32'(bus.digit_valid), 32'(mValid));
      checkEq({tag, ":blank"}, 32'(bus.digit_blank), 32'(mBlank));
      checkEq({tag, ":err"},   32'(bus.digit_err),   32'(mErr));
      if (bus.upd_stb === 1'b1) begin
         stbCount++;
         if (firstStb < 0) firstStb = edgeCount;
      end
   endtask

   task automatic applyStimulus(input string tag, input logic [6:0] seg, input logic [ND-1:0] sel,
                                input logic clr, input int n);
      for (int c = 0; c < n; c++) begin
         bus.seg_n     = seg;
         bus.dig_sel_n = sel;
         bus.clear     = clr;
         @(posedge clk);
         edgeCount++;
         modelEdge(seg, sel, clr);
         @(negedge clk);
         checkOutput(tag);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkEq({tag, ":stb0"},   32'(bus.upd_stb),     32'd0);
      checkEq({tag, ":idx0"},   32'(bus.upd_idx),     32'd0);
      checkEq({tag, ":code0"},  32'(bus.digit_code),  32'd0);
      checkEq({tag, ":valid0"}, 32'(bus.digit_valid), 32'd0);
      checkEq({tag, ":blank0"}, 32'(bus.digit_blank), 32'd0);
      checkEq({tag, ":err0"},   32'(bus.digit_err),   32'd0);
   endtask

   initial begin
      logic [6:0]    rSeg;
      logic [ND-1:0] rSel;
      int kind;

      rst_n = 1'b0;
      bus.seg_n = 7'($urandom);
      bus.dig_sel_n = ND'($urandom);
      bus.clear = 1'($urandom);
      modelReset();
      repeat (3) @(negedge clk);
      checkAllZero("reset");
      rst_n = 1'b1;
      $display("[TB] reset released");

      stbCount = 0;
      applyStimulus("idle_sel", 7'h24, 4'b1111, 1'b0, 20);
      checkEq("idle_no_stb", 32'(stbCount), 32'd0);

      stbCount = 0; firstStb = -1; edgeCount = 0;
      applyStimulus("basic", 7'h24, 4'b1110, 1'b0, 56);
      checkEq("basic_latency", 32'(firstStb), 32'(SC + 2));
      checkEq("basic_one_stb", 32'(stbCount), 32'd1);
      checkEq("basic_code", 32'(bus.digit_code[3:0]), 32'h2);
      checkEq("basic_valid", 32'(bus.digit_valid[0]), 32'd1);

      stbCount = 0;
      applyStimulus("scan0", 7'h79, 4'b1110, 1'b0, 10);
      applyStimulus("scan1", 7'h30, 4'b1101, 1'b0, 10);
      applyStimulus("scan2", 7'h08, 4'b1011, 1'b0, 10);
      applyStimulus("scan3", 7'h46, 4'b0111, 1'b0, 10);
      checkEq("scan_stbs", 32'(stbCount), 32'd4);
      checkEq("scan_code", 32'(bus.digit_code), 32'hCA31);
      checkEq("scan_valid", 32'(bus.digit_valid), 32'hF);

      applyStimulus("glitch_pre", 7'h30, 4'b1101, 1'b0, 10);
      stbCount = 0;
      applyStimulus("glitch", 7'h19, 4'b1101, 1'b0, 3);
      applyStimulus("glitch_back", 7'h30, 4'b1101, 1'b0, 10);
      checkEq("glitch_code", 32'(bus.digit_code[7:4]), 32'h3);
      checkEq("glitch_stbs", 32'(stbCount), 32'd1);

      applyStimulus("blank", 7'h7F, 4'b1011, 1'b0, 10);
      checkEq("blank_flag", 32'(bus.digit_blank[2]), 32'd1);
      checkEq("blank_code", 32'(bus.digit_code[11:8]), 32'h0);
      applyStimulus("errpat", 7'h55, 4'b1011, 1'b0, 10);
      checkEq("err_flag", 32'(bus.digit_err[2]), 32'd1);
      checkEq("err_code", 32'(bus.digit_code[11:8]), 32'h0);
      stbCount = 0;
      applyStimulus("illegal", 7'h24, 4'b1100, 1'b0, 30);
      checkEq("illegal_stbs", 32'(stbCount), 32'd0);

      applyStimulus("collide_pre", 7'h06, 4'b0111, 1'b0, SC + 1);
      applyStimulus("collide", 7'h06, 4'b0111, 1'b1, 1);
      checkEq("collide_stb", 32'(bus.upd_stb), 32'd1);
      checkEq("collide_valid", 32'(bus.digit_valid), 32'h8);
      checkEq("collide_code", 32'(bus.digit_code[15:12]), 32'hE);

      applyStimulus("mid_track", 7'h00, 4'b1110, 1'b0, 3);
      rst_n = 1'b0;
      #1;
      modelReset();
      checkAllZero("async_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      stbCount = 0;
      applyStimulus("post_reset", 7'h00, 4'b1111, 1'b0, 10);
      checkEq("post_reset_stbs", 32'(stbCount), 32'd0);

      for (int r = 0; r < 60; r++) begin
         kind = int'($urandom_range(0, 9));
         if (kind < 7) rSeg = patTable[$urandom_range(0, 15)];
         else if (kind == 7) rSeg = 7'h7F;
         else rSeg = 7'($urandom);
         if ($urandom_range(0, 5) == 0) rSel = ND'($urandom);
         else begin
            rSel = '1;
            rSel[$urandom_range(0, ND - 1)] = 1'b0;
         end
         applyStimulus("random", rSeg, rSel, 1'($urandom_range(0, 15) == 0),
                       int'($urandom_range(1, 8)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
